param_regfile: RTL

PARAM_REGFILE -- requirements
Module: param_regfile

---
 rtl/param_regfile_pkg.sv | 12 +
 rtl/regfile_read_port.sv | 34 +++
 rtl/param_regfile.sv | 77 +++++++
 3 files changed

// File: rtl/param_regfile_pkg.sv
// Shared FSM encodings and parameter defaults for the parameterised register file.
package param_regfile_pkg;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 4;
  localparam int NUM_RD_DEF  = 2;
  localparam int ZERO_R0_DEF = 0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: storage mux, same-cycle write bypass, optional hardwired R0.
// Zero latency; forceZero blanks the port during reset and while the file is being swept.
module regfile_read_port
  import param_regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int ZERO_R0 = ZERO_R0_DEF
) (
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic [ADDR_W-1:0] srcReg,
  input  logic              bypassEn,
  input  logic [ADDR_W-1:0] dstReg,
  input  logic [DATA_W-1:0] dstData,
  input  logic              forceZero,
  output logic [DATA_W-1:0] srcData
);

  logic isZeroReg;

  assign isZeroReg = (ZERO_R0 != 0) && (srcReg == '0);

  always_comb begin
    srcData = '0;
    if (forceZero || isZeroReg) begin
      srcData = '0;
    end else if (bypassEn && (srcReg == dstReg)) begin
      srcData = dstData;
    end else begin
      srcData = regs[srcReg];
    end
  end

endmodule

// File: rtl/param_regfile.sv
// Multi-read-port register file with a clock-by-clock clear sweep (Ready low for DEPTH cycles).
// Reads are combinational; writes land on the next edge; writes and Clear are ignored while sweeping.
module param_regfile
  import param_regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_RD  = NUM_RD_DEF,
  parameter int ZERO_R0 = ZERO_R0_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     WriteReg,
  input  logic [ADDR_W-1:0]        DstReg,
  input  logic [DATA_W-1:0]        DstData,
  input  logic [NUM_RD*ADDR_W-1:0] SrcReg,
  output logic [NUM_RD*DATA_W-1:0] SrcData,
  input  logic                     Clear,
  output logic                     Ready
);

  localparam int DEPTH = 2**ADDR_W;
  // One extra counter bit keeps the last index distinct from the wrapped start value.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [0:0]        state;
  logic [ADDR_W:0]   sweepCnt;
  logic              bypassEn;
  logic              forceZero;
  logic              writeOk;

  assign Ready     = (state == IDLE);
  assign bypassEn  = (state == IDLE) && WriteReg && !Clear;
  assign forceZero = rst || (state == SWEEP);
  assign writeOk   = !((ZERO_R0 != 0) && (DstReg == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sweepCnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (state == IDLE) begin
      if (Clear) begin
        state    <= SWEEP;
        sweepCnt <= '0;
      end else if (WriteReg && writeOk) begin
        regs[DstReg] <= DstData;
      end
    end else begin
      regs[sweepCnt[ADDR_W-1:0]] <= '0;
      sweepCnt <= sweepCnt + (ADDR_W+1)'(1);
      if (sweepCnt == LAST_IDX) begin
        state <= IDLE;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : gRead
    regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .ZERO_R0(ZERO_R0)
    ) uPort (
      .regs     (regs),
      .srcReg   (SrcReg[p*ADDR_W +: ADDR_W]),
      .bypassEn (bypassEn),
      .dstReg   (DstReg),
      .dstData  (DstData),
      .forceZero(forceZero),
      .srcData  (SrcData[p*DATA_W +: DATA_W])
    );
  end

endmodule
